// File: rtl/regfile.sv
// 32 x 32-bit RV32I register file with x0 hardwired to zero.
// Reads are combinational and forward in-flight EX/MEM/WB results, youngest first.
module regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NREGS  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic              ex_we,
   input  logic [ADDR_W-1:0] ex_waddr,
   input  logic [DATA_W-1:0] ex_wdata,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_waddr,
   input  logic [DATA_W-1:0] mem_wdata
);

   // Flop array (not RAM) so the whole file can be cleared asynchronously.
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   always_comb begin
      regs_d = regs_q;
      if (we && (waddr != '0)) begin
         regs_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Shared read mux: x0 beats every forwarding source, then EX > MEM > WB > array.
   function automatic logic [DATA_W-1:0] readPort(
      input logic              rstIn,
      input logic              reIn,
      input logic [ADDR_W-1:0] raddrIn,
      input logic [DATA_W-1:0] storedIn,
      input logic              exWeIn,
      input logic [ADDR_W-1:0] exWaddrIn,
      input logic [DATA_W-1:0] exWdataIn,
      input logic              memWeIn,
      input logic [ADDR_W-1:0] memWaddrIn,
      input logic [DATA_W-1:0] memWdataIn,
      input logic              wbWeIn,
      input logic [ADDR_W-1:0] wbWaddrIn,
      input logic [DATA_W-1:0] wbWdataIn
   );
      logic [DATA_W-1:0] result;
      result = storedIn;
      if (rstIn || !reIn || (raddrIn == '0)) begin
         result = '0;
      end else if (exWeIn && (exWaddrIn == raddrIn)) begin
         result = exWdataIn;
      end else if (memWeIn && (memWaddrIn == raddrIn)) begin
         result = memWdataIn;
      end else if (wbWeIn && (wbWaddrIn == raddrIn)) begin
         result = wbWdataIn;
      end
      return result;
   endfunction

   always_comb begin
      rdata1 = readPort(rst, re1, raddr1, regs_q[raddr1],
                        ex_we, ex_waddr, ex_wdata,
                        mem_we, mem_waddr, mem_wdata,
                        we, waddr, wdata);
      rdata2 = readPort(rst, re2, raddr2, regs_q[raddr2],
                        ex_we, ex_waddr, ex_wdata,
                        mem_we, mem_waddr, mem_wdata,
                        we, waddr, wdata);
   end

endmodule

// File: tb/tb_regfile.sv
// Directed table-driven bench for regfile: reset, x0, write-first bypass,
// forwarding priority and an asynchronous mid-cycle reset pulse.
`timescale 1ns/100ps
module tb_regfile;

   logic        clk;
   logic        rst;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        re1;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;
   logic        ex_we;
   logic [4:0]  ex_waddr;
   logic [31:0] ex_wdata;
   logic        mem_we;
   logic [4:0]  mem_waddr;
   logic [31:0] mem_wdata;

   int checks;
   int failures;

   typedef struct {
      string       name;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        re1;
      logic [4:0]  raddr1;
      logic        re2;
      logic [4:0]  raddr2;
      logic        exWe;
      logic [4:0]  exWaddr;
      logic [31:0] exWdata;
      logic        memWe;
      logic [4:0]  memWaddr;
      logic [31:0] memWdata;
      logic [31:0] exp1;
      logic [31:0] exp2;
   } vec_t;

   vec_t vecs [15];

   regfile #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .re1       (re1),
      .raddr1    (raddr1),
      .rdata1    (rdata1),
      .re2       (re2),
      .raddr2    (raddr2),
      .rdata2    (rdata2),
      .ex_we     (ex_we),
      .ex_waddr  (ex_waddr),
      .ex_wdata  (ex_wdata),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata)
   );

   // 10 ns clock; stimulus changes on the falling edge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      we        = v.we;
      waddr     = v.waddr;
      wdata     = v.wdata;
      re1       = v.re1;
      raddr1    = v.raddr1;
      re2       = v.re2;
      raddr2    = v.raddr2;
      ex_we     = v.exWe;
      ex_waddr  = v.exWaddr;
      ex_wdata  = v.exWdata;
      mem_we    = v.memWe;
      mem_waddr = v.memWaddr;
      mem_wdata = v.memWdata;
      #1;
      checkOutput({v.name, ".rdata1"}, rdata1, v.exp1);
      checkOutput({v.name, ".rdata2"}, rdata2, v.exp2);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      we        = 1'b0;
      waddr     = '0;
      wdata     = '0;
      re1       = 1'b0;
      raddr1    = '0;
      re2       = 1'b0;
      raddr2    = '0;
      ex_we     = 1'b0;
      ex_waddr  = '0;
      ex_wdata  = '0;
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;

      //            name            we waddr  wdata          re1 ra1    re2 ra2    exWe exA   exD            memWe memA  memD           exp1           exp2
      vecs[0]  = '{"x3_wr_bypass", 1, 5'd3,  32'h0000_00AA, 1, 5'd3,  0, 5'd3,  0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         32'h0000_00AA, 32'h0};
      vecs[1]  = '{"x3_rd_re2off", 0, 5'd0,  32'h0,         1, 5'd3,  0, 5'd3,  0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         32'h0000_00AA, 32'h0};
      vecs[2]  = '{"x7_wr",        1, 5'd7,  32'h1,         1, 5'd7,  1, 5'd3,  0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         32'h1,         32'h0000_00AA};
      vecs[3]  = '{"ex_over_mem",  0, 5'd0,  32'h0,         1, 5'd7,  1, 5'd7,  1, 5'd7,  32'h2,         1, 5'd7,  32'h3,         32'h2,         32'h2};
      vecs[4]  = '{"mem_only",     0, 5'd0,  32'h0,         1, 5'd7,  1, 5'd7,  0, 5'd7,  32'h2,         1, 5'd7,  32'h3,         32'h3,         32'h3};
      vecs[5]  = '{"x7_stored",    0, 5'd0,  32'h0,         1, 5'd7,  1, 5'd7,  0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         32'h1,         32'h1};
      vecs[6]  = '{"x0_wr_ex0",    1, 5'd0,  32'h1234_5678, 1, 5'd0,  1, 5'd7,  1, 5'd0,  32'hFFFF_FFFF, 0, 5'd0,  32'h0,         32'h0,         32'h1};
      vecs[7]  = '{"x0_after",     0, 5'd0,  32'h0,         1, 5'd0,  1, 5'd0,  1, 5'd0,  32'hFFFF_FFFF, 1, 5'd0,  32'hFFFF_FFFF, 32'h0,         32'h0};
      vecs[8]  = '{"x9_wr",        1, 5'd9,  32'h10,        1, 5'd9,  1, 5'd9,  0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         32'h10,        32'h10};
      vecs[9]  = '{"x9_bypass",    1, 5'd9,  32'h20,        1, 5'd9,  1, 5'd9,  0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         32'h20,        32'h20};
      vecs[10] = '{"x9_stored",    0, 5'd0,  32'h0,         1, 5'd9,  1, 5'd9,  0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         32'h20,        32'h20};
      vecs[11] = '{"x31_wr",       1, 5'd31, 32'h8000_0001, 1, 5'd31, 1, 5'd31, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         32'h8000_0001, 32'h8000_0001};
      vecs[12] = '{"fwd_other",    0, 5'd0,  32'h0,         1, 5'd3,  1, 5'd4,  1, 5'd4,  32'h55,        0, 5'd0,  32'h0,         32'h0000_00AA, 32'h55};
      vecs[13] = '{"wb_vs_ex",     1, 5'd12, 32'hCAFE_0000, 1, 5'd12, 1, 5'd31, 1, 5'd12, 32'h1234,      0, 5'd0,  32'h0,         32'h1234,      32'h8000_0001};
      vecs[14] = '{"x12_stored",   0, 5'd0,  32'h0,         1, 5'd12, 1, 5'd12, 0, 5'd0,  32'h0,         0, 5'd0,  32'h0,         32'hCAFE_0000, 32'hCAFE_0000};

      // Write attempted while reset is held must be lost; reads are forced to zero.
      @(negedge clk);
      we     = 1'b1;
      waddr  = 5'd5;
      wdata  = 32'hDEAD_BEEF;
      re1    = 1'b1;
      raddr1 = 5'd5;
      re2    = 1'b1;
      raddr2 = 5'd5;
      #1;
      checkOutput("rst_rdata1", rdata1, 32'h0);
      checkOutput("rst_rdata2", rdata2, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("rst_edge_rdata1", rdata1, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      we  = 1'b0;
      #1;
      checkOutput("x5_after_rst", rdata1, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("x5_after_edge", rdata2, 32'h0);

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i]);
      end

      // All three producers target x7 in one cycle; peel them off before the edge.
      @(negedge clk);
      we        = 1'b1;
      waddr     = 5'd7;
      wdata     = 32'h4;
      mem_we    = 1'b1;
      mem_waddr = 5'd7;
      mem_wdata = 32'h3;
      ex_we     = 1'b1;
      ex_waddr  = 5'd7;
      ex_wdata  = 32'h2;
      re1       = 1'b1;
      raddr1    = 5'd7;
      re2       = 1'b1;
      raddr2    = 5'd7;
      #1;
      checkOutput("prio_ex.rdata1", rdata1, 32'h2);
      checkOutput("prio_ex.rdata2", rdata2, 32'h2);
      ex_we = 1'b0;
      #1;
      checkOutput("prio_mem.rdata1", rdata1, 32'h3);
      checkOutput("prio_mem.rdata2", rdata2, 32'h3);
      mem_we = 1'b0;
      #1;
      checkOutput("prio_wb.rdata1", rdata1, 32'h4);
      checkOutput("prio_wb.rdata2", rdata2, 32'h4);
      @(posedge clk);
      #1;
      we = 1'b0;
      #1;
      checkOutput("prio_stored.rdata1", rdata1, 32'h4);
      checkOutput("prio_stored.rdata2", rdata2, 32'h4);

      // Load x1..x31 with their own index.
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         we    = 1'b1;
         waddr = 5'(i);
         wdata = 32'(i);
      end
      @(negedge clk);
      we = 1'b0;
      for (int i = 1; i < 32; i++) begin
         raddr1 = 5'(i);
         raddr2 = 5'(32 - i);
         #0.1;
         checkOutput($sformatf("load_x%0d", i), rdata1, 32'(i));
      end

      // Short reset pulse strictly between clock edges must clear the array at once.
      @(posedge clk);
      #1;
      raddr1 = 5'd17;
      raddr2 = 5'd31;
      rst    = 1'b1;
      #0.5;
      checkOutput("pulse_rdata1", rdata1, 32'h0);
      checkOutput("pulse_rdata2", rdata2, 32'h0);
      #1;
      rst = 1'b0;
      for (int i = 1; i < 32; i++) begin
         raddr1 = 5'(i);
         raddr2 = 5'(32 - i);
         #0.1;
         checkOutput($sformatf("cleared_p1_x%0d", i), rdata1, 32'h0);
         checkOutput($sformatf("cleared_p2_x%0d", 32 - i), rdata2, 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
